ret_stack_ctrl: RTL and testbench
=================================

RET_STACK_CTRL -- requirements
Module: ret_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of return-address entries (power of two, 2..32).
REQ-002 SHALL have parameter AW, default 8, meaning address width of pcout/pila.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cs, input, 5, control-unit state code; sampled every rising edge.
REQ-006 SHALL have port pcout, input, AW, return address to push.
REQ-007 SHALL have port flush, input, 1, synchronous stack clear.
REQ-008 SHALL have port pila, output, AW, last popped return address (registered).
REQ-009 SHALL have port ret_valid, output, 1, one-cycle pulse: pila updated by a pop this cycle.
REQ-010 SHALL have port empty, output, 1, no entries held.
REQ-011 SHALL have port full, output, 1, DEPTH entries held.
REQ-012 SHALL have port depth, output, $clog2(DEPTH)+1, current entry count.

Function
REQ-013 SHALL decode cs = CS_CALL (5'b11100) as push and cs = CS_RET (5'b11101) as pop; all other codes as no-op.
REQ-014 SHALL implement FSM states S_EMPTY, S_PART, S_FULL, S_ERR; state follows entry count after each accepted op.
REQ-015 SHALL on accepted push write pcout to mem[sp] and increment sp at the same edge; pila unchanged, ret_valid low.
REQ-016 SHALL on accepted pop load pila <= mem[sp-1], decrement sp, and assert ret_valid for exactly the following cycle (latency 1 edge).
REQ-017 SHALL ignore push in S_FULL (sp, mem, pila unchanged) and pop in S_EMPTY (sp, pila unchanged, ret_valid low).
REQ-018 SHALL give flush priority over cs: flush high at an edge sets sp=0, state S_EMPTY, ret_valid=0; pila retains value.
REQ-019 SHALL derive empty = (sp==0), full = (sp==DEPTH), depth = sp, combinationally from registered sp.
REQ-020 SHALL support back-to-back push/pop every cycle with no bubble; push-then-pop returns the pushed value.
REQ-021 SHALL never wrap sp: sp stays within 0..DEPTH.

Reset
REQ-022 SHALL on reset asynchronously set sp=0, state S_EMPTY, pila=0, ret_valid=0; mem contents need not be cleared.
REQ-023 SHALL abort any op sampled in the reset cycle; first op is accepted on the first rising edge after reset deasserts.

Configuration
REQ-024 SHALL, with RET_STACK_ERR_EN defined, provide outputs ovf and unf (1 bit each), set sticky on ignored push/pop respectively, and enter S_ERR where all push/pop are ignored until flush or reset clears ovf, unf and returns to S_EMPTY.
REQ-025 SHALL, without RET_STACK_ERR_EN, omit ovf/unf ports and S_ERR; ignored ops only leave state unchanged per REQ-017.

Structure
REQ-026 SHALL place CS_CALL, CS_RET codes and the state enum typedef in shared package ret_stack_pkg.
REQ-027 SHALL instantiate one sub-module ret_stack_mem: DEPTH x AW register array, one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-028 Reset, then push 0x10, 0x20, 0x30 -> depth=3; pop x3 -> pila 0x30, 0x20, 0x10, each with 1-cycle ret_valid; empty=1.
REQ-029 Push 8 values 0x01..0x08 -> full=1; push 0x09 -> depth stays 8; pop -> pila=0x08 (ERR_EN: ovf=1, pop ignored, pila unchanged).
REQ-030 Pop at empty -> ret_valid=0, pila unchanged (ERR_EN: unf=1, S_ERR); flush -> empty=1, ovf=unf=0.
REQ-031 Alternate push 0xA5/pop every cycle for 16 cycles -> pila=0xA5 each pop, depth toggles 0/1, no lost cycle.
REQ-032 cs=CS_CALL with flush=1 -> depth=0; reset asserted mid-sequence at depth 5 -> immediately depth=0, pila=0, ret_valid=0.

Source files
------------

// File: rtl/ret_stack_pkg.sv
// Shared control-unit codes and state type for the return-address stack.
// RET_STACK_ERR_EN adds the sticky error state S_ERR.
package ret_stack_pkg;

  localparam logic [4:0] CS_CALL = 5'b11100;
  localparam logic [4:0] CS_RET  = 5'b11101;

`ifdef RET_STACK_ERR_EN
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2,
    S_ERR   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/ret_stack_mem.sv
// Return-address storage: DEPTH x AW registers, synchronous write, async read.
// Contents are not reset; the stack pointer alone defines what is valid.
module ret_stack_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ret_stack_ctrl.sv
// Return-address stack controller: push on CS_CALL, pop on CS_RET, flush clears.
// Define RET_STACK_ERR_EN for sticky ovf/unf outputs and the S_ERR lockout state.
module ret_stack_ctrl
  import ret_stack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               cs,
  input  logic [AW-1:0]            pcout,
  input  logic                     flush,
  output logic [AW-1:0]            pila,
  output logic                     ret_valid,
  output logic                     empty,
  output logic                     full,
`ifdef RET_STACK_ERR_EN
  output logic                     ovf,
  output logic                     unf,
`endif
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  state_e         state_q, state_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  pila_d, rdata;
  logic [IW-1:0]  raddr;
  logic           rv_d, we, push, pop, ops_en;
`ifdef RET_STACK_ERR_EN
  logic           ovf_d, unf_d;
`endif

  assign push  = (cs == CS_CALL);
  assign pop   = (cs == CS_RET);
  assign raddr = sp_q[IW-1:0] - IW'(1);

  ret_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (sp_q[IW-1:0]),
    .wdata (pcout),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      sp_q      <= '0;
      pila      <= '0;
      ret_valid <= 1'b0;
`ifdef RET_STACK_ERR_EN
      ovf       <= 1'b0;
      unf       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      pila      <= pila_d;
      ret_valid <= rv_d;
`ifdef RET_STACK_ERR_EN
      ovf       <= ovf_d;
      unf       <= unf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    pila_d  = pila;
    rv_d    = 1'b0;
    we      = 1'b0;
`ifdef RET_STACK_ERR_EN
    ovf_d   = ovf;
    unf_d   = unf;
    ops_en  = (state_q != S_ERR);
`else
    ops_en  = 1'b1;
`endif

    if (flush) begin
      sp_d = '0;
`ifdef RET_STACK_ERR_EN
      ovf_d = 1'b0;
      unf_d = 1'b0;
`endif
    end else if (ops_en) begin
      if (push) begin
        if (state_q != S_FULL) begin
          we   = 1'b1;
          sp_d = sp_q + SPW'(1);
        end else begin
`ifdef RET_STACK_ERR_EN
          ovf_d = 1'b1;
`endif
        end
      end else if (pop) begin
        if (state_q != S_EMPTY) begin
          pila_d = rdata;
          sp_d   = sp_q - SPW'(1);
          rv_d   = 1'b1;
        end else begin
`ifdef RET_STACK_ERR_EN
          unf_d = 1'b1;
`endif
        end
      end
    end

    // State tracks the post-edge entry count; a sticky error overrides it.
    if (sp_d == '0)           state_d = S_EMPTY;
    else if (sp_d == SP_FULL) state_d = S_FULL;
    else                      state_d = S_PART;
`ifdef RET_STACK_ERR_EN
    if (ovf_d || unf_d) state_d = S_ERR;
`endif
  end

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SP_FULL);
  assign depth = sp_q;

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// Self-checking bench for ret_stack_ctrl (default build, RET_STACK_ERR_EN undefined).
module tb_ret_stack_ctrl;
  import ret_stack_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 8;
  localparam logic [4:0] NOP = 5'd0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [4:0] cs = '0;
  logic [7:0] pcout = '0;
  logic [7:0] pila;
  logic       ret_valid, empty, full;
  logic [3:0] depth;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_stack[$];
  logic [7:0] m_pila = '0;
  logic       m_rv = 1'b0;
  bit         cmp_en = 1'b1;

  always #5 clk = ~clk;

  ret_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .pcout     (pcout),
    .flush     (flush),
    .pila      (pila),
    .ret_valid (ret_valid),
    .empty     (empty),
    .full      (full),
    .depth     (depth)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a LIFO queue plus the last popped value.
  task automatic model_edge();
    if (reset) begin
      m_stack.delete();
      m_pila = '0;
      m_rv   = 1'b0;
    end else if (flush) begin
      m_stack.delete();
      m_rv = 1'b0;
    end else if (cs == CS_CALL && m_stack.size() < DEPTH) begin
      m_stack.push_back(pcout);
      m_rv = 1'b0;
    end else if (cs == CS_RET && m_stack.size() > 0) begin
      m_pila = m_stack.pop_back();
      m_rv   = 1'b1;
    end else begin
      m_rv = 1'b0;
    end
  endtask

  task automatic step(input logic [4:0] c, input logic [7:0] d, input logic f);
    cs    = c;
    pcout = d;
    flush = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pila",      32'(pila),      32'(m_pila));
      chk("ret_valid", 32'(ret_valid), 32'(m_rv));
      chk("depth",     32'(depth),     32'(m_stack.size()));
      chk("empty",     32'(empty),     32'(m_stack.size() == 0));
      chk("full",      32'(full),      32'(m_stack.size() == DEPTH));
    end
  end

  initial begin
    repeat (2) step(CS_CALL, 8'hEE, 1'b0);
    chk("reset_depth", 32'(depth), 32'd0);
    chk("reset_pila",  32'(pila),  32'd0);
    reset = 1'b0;

    // LIFO order with one-cycle ret_valid
    step(CS_CALL, 8'h10, 1'b0);
    step(CS_CALL, 8'h20, 1'b0);
    step(CS_CALL, 8'h30, 1'b0);
    chk("depth3", 32'(depth), 32'd3);
    step(CS_RET, 8'h00, 1'b0);
    chk("pop30", 32'(pila), 32'h30);
    chk("rv30",  32'(ret_valid), 32'd1);
    step(CS_RET, 8'h00, 1'b0);
    chk("pop20", 32'(pila), 32'h20);
    step(CS_RET, 8'h00, 1'b0);
    chk("pop10", 32'(pila), 32'h10);
    chk("rv10",  32'(ret_valid), 32'd1);
    step(NOP, 8'h00, 1'b0);
    chk("rv_drop",   32'(ret_valid), 32'd0);
    chk("empty_end", 32'(empty), 32'd1);

    // Fill, overflow attempt, pop
    for (int i = 1; i <= 8; i++) step(CS_CALL, 8'(i), 1'b0);
    chk("full8", 32'(full), 32'd1);
    step(CS_CALL, 8'h09, 1'b0);
    chk("ovf_depth", 32'(depth), 32'd8);
    step(CS_RET, 8'h00, 1'b0);
    chk("pop08", 32'(pila), 32'h08);
    repeat (7) step(CS_RET, 8'h00, 1'b0);
    chk("pop01", 32'(pila), 32'h01);

    // Underflow attempt, then flush
    step(CS_RET, 8'h00, 1'b0);
    chk("unf_rv",   32'(ret_valid), 32'd0);
    chk("unf_pila", 32'(pila), 32'h01);
    step(CS_CALL, 8'h55, 1'b0);
    step(NOP, 8'h00, 1'b1);
    chk("flush_empty", 32'(empty), 32'd1);

    // Back-to-back push/pop
    for (int i = 0; i < 8; i++) begin
      step(CS_CALL, 8'hA5, 1'b0);
      chk("alt_d1", 32'(depth), 32'd1);
      step(CS_RET, 8'h00, 1'b0);
      chk("alt_pop", 32'(pila), 32'hA5);
      chk("alt_d0", 32'(depth), 32'd0);
    end

    // Flush beats push; async reset mid-sequence
    step(CS_CALL, 8'h77, 1'b1);
    chk("flush_prio", 32'(depth), 32'd0);
    for (int i = 0; i < 6; i++) step(CS_CALL, 8'(8'h41 + i), 1'b0);
    step(CS_RET, 8'h00, 1'b0);
    chk("pre_rst_depth", 32'(depth), 32'd5);
    chk("pre_rst_pila",  32'(pila), 32'h46);
    #2 reset = 1'b1;
    model_edge();
    #1;
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_pila",  32'(pila), 32'd0);
    chk("rst_rv",    32'(ret_valid), 32'd0);
    step(CS_CALL, 8'h99, 1'b0);
    chk("rst_abort", 32'(depth), 32'd0);
    reset = 1'b0;
    step(CS_CALL, 8'h99, 1'b0);
    chk("post_rst", 32'(depth), 32'd1);

    // Randomized traffic: push-biased first half, pop-biased second half
    for (int n = 0; n < 800; n++) begin
      int r;
      logic [4:0] c;
      r = $urandom_range(0, 99);
      if (n < 400) c = (r < 60) ? CS_CALL : (r < 88) ? CS_RET : 5'($urandom_range(0, 27));
      else         c = (r < 30) ? CS_CALL : (r < 88) ? CS_RET : 5'($urandom_range(0, 27));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        model_edge();
        step(c, 8'($urandom), 1'b0);
        reset = 1'b0;
      end else begin
        step(c, 8'($urandom), 1'($urandom_range(0, 99) < 2));
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
